// File: rtl/mips32_ifetch_if.sv
// Bus bundle of the MIPS32 fetch stage: instruction-memory req/gnt/rvalid
// channel plus the valid/ready handshake towards decode.
interface mips32_ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
endinterface

// File: rtl/mips32_ifetch.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem reads,
// buffers returned words in a prefetch FIFO and flushes on EX redirects.
module mips32_ifetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  mips32_ifetch_if.master bus,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  output logic [31:0]     pc,
  output logic            err
);
  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = CW'(1'b0);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
  localparam logic [PW-1:0] PONE_C  = PW'(1'b1);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_q, req_d;
  logic          err_q, err_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0] aw_q, aw_d, ar_q, ar_d;
  logic          valid_q, valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   ipc_q, ipc_d;

  logic [31:0]   fifo_instr_mem [DEPTH];
  logic [31:0]   fifo_pc_mem    [DEPTH];
  logic [31:0]   addr_mem       [DEPTH];

  logic          gnt_acc_s, rv_acc_s, redir_s, push_s, pop_s;
  logic [31:0]   rsp_addr_s;
  logic [CW-1:0] remain_s;

  // Next-state: bus accounting, PC, prefetch FIFO with registered head, FSM.
  always_comb begin
    gnt_acc_s  = req_q & bus.imem_gnt;
    // A response is only legal while something is outstanding.
    rv_acc_s   = bus.imem_rvalid & (out_q != ZERO_C);
    redir_s    = redirect & (state_q != S_BOOT);
    push_s     = rv_acc_s & (state_q == S_FETCH) & ~redir_s;
    pop_s      = valid_q & bus.if_ready;
    rsp_addr_s = addr_mem[ar_q];

    state_d  = state_q;
    pc_d     = pc_q;
    err_d    = err_q | (bus.imem_rvalid & (out_q == ZERO_C));
    out_d    = out_q + (gnt_acc_s ? ONE_C : ZERO_C) - (rv_acc_s ? ONE_C : ZERO_C);
    aw_d     = gnt_acc_s ? (aw_q + PONE_C) : aw_q;
    ar_d     = rv_acc_s ? (ar_q + PONE_C) : ar_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    remain_s = cnt_q - (pop_s ? ONE_C : ZERO_C);

    if (redir_s) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (gnt_acc_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    if (redir_s) begin
      cnt_d = ZERO_C;
      wr_d  = PW'(1'b0);
      rd_d  = PW'(1'b0);
    end else begin
      cnt_d = remain_s + (push_s ? ONE_C : ZERO_C);
      wr_d  = push_s ? (wr_q + PONE_C) : wr_q;
      rd_d  = pop_s ? (rd_q + PONE_C) : rd_q;
      // Head comes from storage if anything survives the pop, else bypasses the push.
      if (remain_s != ZERO_C) begin
        instr_d = fifo_instr_mem[rd_d];
        ipc_d   = fifo_pc_mem[rd_d];
      end else if (push_s) begin
        instr_d = bus.imem_rdata;
        ipc_d   = rsp_addr_s;
      end else begin
        instr_d = instr_q;
        ipc_d   = ipc_q;
      end
    end
    valid_d = (cnt_d != ZERO_C);

    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: begin
        if (redir_s && (out_d != ZERO_C)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (out_d == ZERO_C) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_BOOT;
    endcase

    req_d = (state_d == S_FETCH) && ((out_d + cnt_d) < DEPTH_C);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= ZERO_C;
      cnt_q   <= ZERO_C;
      wr_q    <= PW'(1'b0);
      rd_q    <= PW'(1'b0);
      aw_q    <= PW'(1'b0);
      ar_q    <= PW'(1'b0);
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      err_q   <= err_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      aw_q    <= aw_d;
      ar_q    <= ar_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // FIFO payload and in-flight request-address queue storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr_mem[i] <= 32'd0;
        fifo_pc_mem[i]    <= 32'd0;
        addr_mem[i]       <= 32'd0;
      end
    end else begin
      if (push_s) begin
        fifo_instr_mem[wr_q] <= bus.imem_rdata;
        fifo_pc_mem[wr_q]    <= rsp_addr_s;
      end
      if (gnt_acc_s) begin
        addr_mem[aw_q] <= pc_q;
      end
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ipc_q;
  assign pc            = pc_q;
  assign err           = err_q;
endmodule

// File: tb/tb_mips32_ifetch.sv
// Self-checking bench for mips32_ifetch: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_mips32_ifetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] pc;
  logic        err;
  logic        gnt_en = 1'b1;
  logic        ready = 1'b1;
  logic        stray = 1'b0;
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_d = 32'd0;
  int          lat = 1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic [31:0] pend_a[$];
  int          pend_due[$];
  logic [31:0] glog[$];
  logic [31:0] alog[$];
  int          acyc[$];

  mips32_ifetch_if bus ();

  mips32_ifetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc), .err(err)
  );

  always #5 clk = ~clk;

  assign bus.imem_gnt    = gnt_en & bus.imem_req;
  assign bus.imem_rvalid = rsp_v | stray;
  assign bus.imem_rdata  = stray ? 32'hBAD0_BAD0 : rsp_d;
  assign bus.if_ready    = ready;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gget(input int i);
    return (i < glog.size()) ? glog[i] : 32'hEEEE_EEEE;
  endfunction
  function automatic logic [31:0] aget(input int i);
    return (i < alog.size()) ? alog[i] : 32'hEEEE_EEEE;
  endfunction
  function automatic int cget(input int i);
    return (i < acyc.size()) ? acyc[i] : -100;
  endfunction

  // Memory side: log grants/accepts, schedule responses lat cycles after grant.
  initial forever begin
    @(posedge clk);
    if (rst_n) begin
      if (bus.imem_req && bus.imem_gnt) begin
        pend_a.push_back(bus.imem_addr);
        pend_due.push_back(cyc + lat);
        glog.push_back(bus.imem_addr);
      end
      if (bus.if_valid && ready) begin
        alog.push_back(bus.if_pc);
        acyc.push_back(cyc);
      end
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && pend_a.size() > 0 && pend_due[0] <= cyc) begin
      rsp_v = 1'b1;
      rsp_d = word_of(pend_a[0]);
      void'(pend_a.pop_front());
      void'(pend_due.pop_front());
    end else begin
      rsp_v = 1'b0;
      rsp_d = 32'd0;
    end
  end

  // Reference model: outstanding requests tagged stale on redirect, plain FIFO of words.
  typedef struct packed { logic [31:0] a; logic st; } oq_t;
  typedef struct packed { logic [31:0] i; logic [31:0] p; } fq_t;
  oq_t         m_oq[$];
  fq_t         m_fq[$];
  logic [31:0] m_pc = 32'd0;
  logic        m_err = 1'b0;
  logic        m_boot = 1'b1;

  function automatic bit m_req_f();
    if (m_boot) return 1'b0;
    if (m_oq.size() + m_fq.size() >= 4) return 1'b0;
    for (int k = 0; k < m_oq.size(); k++) if (m_oq[k].st) return 1'b0;
    return 1'b1;
  endfunction

  initial begin : model_p
    oq_t e;
    bit  req_now, redir, popv;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_oq.delete(); m_fq.delete();
        m_pc = 32'd0; m_err = 1'b0; m_boot = 1'b1;
      end else begin
        req_now = m_req_f();
        redir   = redirect && !m_boot;
        popv    = (m_fq.size() > 0) && ready;
        if (popv) void'(m_fq.pop_front());
        if (bus.imem_rvalid) begin
          if (m_oq.size() == 0) m_err = 1'b1;
          else begin
            e = m_oq.pop_front();
            if (!e.st && !redir) m_fq.push_back(fq_t'({bus.imem_rdata, e.a}));
          end
        end
        if (req_now && gnt_en) begin
          m_oq.push_back(oq_t'({m_pc, redir}));
          m_pc = m_pc + 32'd4;
        end
        if (redir) begin
          for (int k = 0; k < m_oq.size(); k++) m_oq[k].st = 1'b1;
          m_fq.delete();
          m_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        m_boot = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("m_req",   32'(bus.imem_req), 32'(m_req_f()));
      chk("m_addr",  bus.imem_addr, m_pc);
      chk("m_pc",    pc, m_pc);
      chk("m_valid", 32'(bus.if_valid), 32'(m_fq.size() > 0));
      if (m_fq.size() > 0) begin
        chk("m_instr", bus.if_instr, m_fq[0].i);
        chk("m_ifpc",  bus.if_pc, m_fq[0].p);
      end
      chk("m_err",   32'(err), 32'(m_err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input logic g);
    tick();
    rst_n = 1'b0; redirect = 1'b0; stray = 1'b0;
    ready = rdy; gnt_en = g; lat = 1;
    pend_a.delete(); pend_due.delete();
    glog.delete(); alog.delete(); acyc.delete();
    tick();
    tick();
  endtask

  int n, gn;

  initial begin
    // 1: reset values, then streaming fetch at one instruction per clock
    do_reset(1'b1, 1'b1);
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_ifpc",  bus.if_pc, 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_pc",    pc, 32'd0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t1_a0", aget(0), 32'h0);
    chk("t1_a1", aget(1), 32'h4);
    chk("t1_a2", aget(2), 32'h8);
    chk("t1_b2b", 32'(cget(2) - cget(0)), 32'd2);

    // 2: decode stalled -> exactly four grants, then resume without loss
    do_reset(1'b0, 1'b1);
    rst_n = 1'b1;
    repeat (15) tick();
    chk("t2_ngrant", 32'(glog.size()), 32'd4);
    chk("t2_req",    32'(bus.imem_req), 32'd0);
    chk("t2_valid",  32'(bus.if_valid), 32'd1);
    chk("t2_head",   bus.if_pc, 32'd0);
    ready = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < 8; i++) chk("t2_seq", aget(i), 32'(4 * i));
    chk("t2_resume", gget(4), 32'h10);

    // 3: slow responses, redirect with two outstanding -> drain, then 0x100
    do_reset(1'b1, 1'b1);
    lat = 3;
    rst_n = 1'b1;
    for (int k = 0; k < 10 && glog.size() < 2; k++) tick();
    chk("t3_two_out", 32'(glog.size()), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h0000_0100; gnt_en = 1'b0;
    tick();
    redirect = 1'b0; gnt_en = 1'b1; lat = 1;
    chk("t3_drain_req",   32'(bus.imem_req), 32'd0);
    chk("t3_drain_valid", 32'(bus.if_valid), 32'd0);
    tick();
    chk("t3_drain_valid2", 32'(bus.if_valid), 32'd0);
    for (int k = 0; k < 15 && alog.size() < 2; k++) tick();
    chk("t3_first", aget(0), 32'h100);
    chk("t3_second", aget(1), 32'h104);
    chk("t3_req_new", gget(2), 32'h100);

    // 4: redirect to 0x203 coinciding with a grant and a head transfer
    do_reset(1'b1, 1'b1);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("t4_req_pre",   32'(bus.imem_req), 32'd1);
    chk("t4_valid_pre", 32'(bus.if_valid), 32'd1);
    n  = alog.size();
    gn = glog.size();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 10 && glog.size() < gn + 2; k++) tick();
    chk("t4_gnt_redir", gget(gn), 32'(4 * gn));
    chk("t4_next_req",  gget(gn + 1), 32'h200);
    for (int k = 0; k < 10 && alog.size() < n + 2; k++) tick();
    chk("t4_head_once", aget(n), 32'(4 * n));
    chk("t4_after",     aget(n + 1), 32'h200);

    // 5: stray rvalid -> sticky err, FIFO untouched
    do_reset(1'b0, 1'b1);
    rst_n = 1'b1;
    repeat (15) tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("t5_err",    32'(err), 32'd1);
    chk("t5_valid",  32'(bus.if_valid), 32'd1);
    chk("t5_head",   bus.if_pc, 32'd0);
    chk("t5_instr",  bus.if_instr, word_of(32'd0));
    repeat (5) tick();
    chk("t5_sticky", 32'(err), 32'd1);
    ready = 1'b1;
    repeat (15) tick();
    for (int i = 0; i < 6; i++) chk("t5_seq", aget(i), 32'(4 * i));
    do_reset(1'b1, 1'b1);
    chk("t5_err_clr", 32'(err), 32'd0);

    // 6: redirect near the top of memory -> PC wraps to zero
    do_reset(1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_req_idle", 32'(bus.imem_req), 32'd1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0; gnt_en = 1'b1;
    chk("t6_addr", bus.imem_addr, 32'hFFFF_FFF8);
    for (int k = 0; k < 20 && pc != 32'd0; k++) tick();
    chk("t6_pc_wrap", pc, 32'd0);
    repeat (4) tick();
    chk("t6_g0", gget(0), 32'hFFFF_FFF8);
    chk("t6_g1", gget(1), 32'hFFFF_FFFC);
    chk("t6_g2", gget(2), 32'h0000_0000);
    chk("t6_a0", aget(0), 32'hFFFF_FFF8);
    chk("t6_a1", aget(1), 32'hFFFF_FFFC);
    chk("t6_a2", aget(2), 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
